// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared encodings and register map for the down-counting timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timerState_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;

  // Only the exact periodic encoding reloads; 2'b10 and 2'b11 fall back to one-shot.
  function automatic logic isPeriodic(input logic [1:0] mode);
    return (mode == MODE_PERIODIC) && (mode != MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped one-shot / auto-reload down-counter with irq
module timer_counter
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  logic [3:0]       ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irqPend;
  timerState_e      state;

  logic ctrlWr;
  logic presetWr;
  logic irqSet;

  assign ctrlWr   = we && (addr == REG_CTRL);
  assign presetWr = we && (addr == REG_PRESET);
  // The expiring CNT cycle; a CPU CTRL write landing on it must not swallow the new interrupt.
  assign irqSet   = (state == CNT) && ctrl[CTRL_EN] && (count <= CNT_W'(1));

  // FSM, counter and register file; CPU writes are placed last so they win over FSM updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      irqPend <= 1'b0;
      state   <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl[CTRL_EN]) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            // A preset of 0 lands here on the first count cycle, same as a preset of 1.
            count   <= '0;
            irqPend <= 1'b1;
            state   <= INT;
          end
        end
        INT: begin
          if (isPeriodic(ctrl[CTRL_MODE_HI:CTRL_MODE_LO])) begin
            // EN is still set, so go straight to the reload: the period is PRESET+2 cycles.
            irqPend <= 1'b0;
            state   <= LOAD;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (ctrlWr) begin
        ctrl <= wd[3:0];
        if (!irqSet) irqPend <= 1'b0;
      end
      if (presetWr) preset <= wd[CNT_W-1:0];
    end
  end

  // Combinational read mux; narrow registers are zero-extended and addr 3 reads 0.
  always_comb begin
    rd = '0;
    case (addr)
      REG_CTRL:   rd[3:0]       = ctrl;
      REG_PRESET: rd[CNT_W-1:0] = preset;
      REG_COUNT:  rd[CNT_W-1:0] = count;
      default:    rd            = '0;
    endcase
  end

  assign irq = ctrl[CTRL_IM] & irqPend;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - self-checking bench for timer_counter
module tb_timer_counter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;

  int cmpCount = 0;
  int errCount = 0;

  timer_counter #(.CNT_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: timer activity as flags (armed / running / fired) plus register values.
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;
    logic        armed;
    logic        running;
    logic        fired;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t stepModel(input mdl_t cur, input logic w, input logic [1:0] a,
                                     input logic [31:0] d);
    mdl_t n;
    logic en;
    logic periodic;
    logic fireNow;
    n        = cur;
    en       = cur.ctrl[0];
    periodic = (cur.ctrl[2:1] == 2'b01);
    fireNow  = 1'b0;
    if (cur.fired) begin
      n.fired = 1'b0;
      if (periodic) begin
        n.pend  = 1'b0;
        n.armed = 1'b1;
      end else begin
        n.ctrl[0] = 1'b0;
      end
    end else if (cur.armed) begin
      n.armed   = 1'b0;
      n.running = 1'b1;
      n.count   = cur.preset;
    end else if (cur.running) begin
      if (!en) begin
        n.running = 1'b0;
      end else if (cur.count >= 32'd2) begin
        n.count = cur.count - 32'd1;
      end else begin
        n.count   = 32'd0;
        n.pend    = 1'b1;
        n.running = 1'b0;
        n.fired   = 1'b1;
        fireNow   = 1'b1;
      end
    end else if (en) begin
      n.armed = 1'b1;
    end
    if (w && a == 2'd0) begin
      n.ctrl = d[3:0];
      if (!fireNow) n.pend = 1'b0;
    end
    if (w && a == 2'd1) n.preset = d;
    return n;
  endfunction

  // Advance the model on every clock edge, resetting with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= stepModel(m, we, addr, wd);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      errCount++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Compare the DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    logic [31:0] expRd;
    if (rst_n) begin
      case (addr)
        2'd0:    expRd = {28'd0, m.ctrl};
        2'd1:    expRd = m.preset;
        2'd2:    expRd = m.count;
        default: expRd = 32'd0;
      endcase
      chk("model rd", rd, expRd);
      chk("model irq", {31'd0, irq}, {31'd0, m.ctrl[3] & m.pend});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wrReg(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rdChk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rd, exp);
  endtask

  task automatic waitIrq(input string name, input int maxC, output int n);
    n = 0;
    while (!irq && n < maxC) begin
      tick(1);
      n++;
    end
    if (!irq) chk(name, {31'd0, irq}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int pulses;
    int firstAt;
    int lastAt;
    int gapBad;
    int seenIrq;
    int n;

    rst_n = 1'b0;
    we    = 1'b0;
    addr  = 2'd0;
    wd    = 32'd0;

    // Reset state
    #12;
    rdChk("reset ctrl", 2'd0, 32'd0);
    rdChk("reset preset", 2'd1, 32'd0);
    rdChk("reset count", 2'd2, 32'd0);
    chk("reset irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);

    // One-shot: PRESET=3, CTRL=9
    wrReg(2'd1, 32'd3);
    wrReg(2'd0, 32'd9);
    tick(1);
    tick(1); rdChk("oneshot count t+2", 2'd2, 32'd3);
    tick(1); rdChk("oneshot count t+3", 2'd2, 32'd2);
    tick(1); rdChk("oneshot count t+4", 2'd2, 32'd1);
    chk("oneshot irq low t+4", {31'd0, irq}, 32'd0);
    tick(1); rdChk("oneshot count t+5", 2'd2, 32'd0);
    chk("oneshot irq t+5", {31'd0, irq}, 32'd1);
    tick(1); rdChk("oneshot ctrl EN cleared", 2'd0, 32'd8);
    tick(3);
    chk("oneshot irq held", {31'd0, irq}, 32'd1);
    wrReg(2'd0, 32'd0);
    chk("oneshot irq cleared by ctrl", {31'd0, irq}, 32'd0);
    tick(2);

    // Periodic: PRESET=4, CTRL=0xB
    wrReg(2'd1, 32'd4);
    wrReg(2'd0, 32'hB);
    pulses  = 0;
    firstAt = 0;
    lastAt  = 0;
    gapBad  = 0;
    for (int i = 1; i <= 18; i++) begin
      tick(1);
      if (irq) begin
        if (pulses == 0) firstAt = i;
        else if (i - lastAt != 6) gapBad++;
        lastAt = i;
        pulses++;
      end
    end
    chk("periodic pulses", pulses, 32'd3);
    chk("periodic first", firstAt, 32'd6);
    chk("periodic gap", gapBad, 32'd0);
    wrReg(2'd0, 32'd0);
    tick(4);

    // Masking: IM=0
    wrReg(2'd1, 32'd2);
    wrReg(2'd0, 32'd1);
    seenIrq = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (irq) seenIrq++;
    end
    chk("mask irq quiet", seenIrq, 32'd0);
    rdChk("mask count zero", 2'd2, 32'd0);
    rdChk("mask ctrl EN cleared", 2'd0, 32'd0);
    wrReg(2'd0, 32'd8);
    chk("mask IM set, pend cleared", {31'd0, irq}, 32'd0);
    rdChk("mask ctrl readback", 2'd0, 32'd8);
    wrReg(2'd0, 32'd0);
    tick(2);

    // Collision: CTRL=0xB written in the one-shot INT cycle
    wrReg(2'd1, 32'd2);
    wrReg(2'd0, 32'd9);
    waitIrq("collide first irq timeout", 10, n);
    chk("collide first irq latency", n, 32'd4);
    wrReg(2'd0, 32'hB);
    rdChk("collide EN kept", 2'd0, 32'hB);
    chk("collide pend cleared", {31'd0, irq}, 32'd0);
    waitIrq("collide reload timeout", 10, n);
    chk("collide reload latency", n, 32'd4);
    wrReg(2'd0, 32'd0);
    tick(3);

    // PRESET written mid-count, COUNT write ignored
    wrReg(2'd1, 32'd10);
    wrReg(2'd0, 32'd3);
    tick(1);
    tick(1); rdChk("midcount count t+2", 2'd2, 32'd10);
    tick(1);
    wrReg(2'd1, 32'd7);
    rdChk("midcount undisturbed", 2'd2, 32'd8);
    rdChk("midcount preset", 2'd1, 32'd7);
    tick(10);
    rdChk("midcount new preset loaded", 2'd2, 32'd7);
    wrReg(2'd2, 32'h55);
    rdChk("count write ignored", 2'd2, 32'd6);
    rdChk("addr3 reads zero", 2'd3, 32'd0);
    wrReg(2'd0, 32'd0);
    tick(3);

    // Mode 2'b10 behaves as one-shot, PRESET=0 behaves as 1
    wrReg(2'd1, 32'd0);
    wrReg(2'd0, 32'h5);
    tick(1);
    tick(1);
    tick(1); rdChk("mode2 preset0 fires", 2'd2, 32'd0);
    tick(1); rdChk("mode2 EN cleared", 2'd0, 32'h4);
    wrReg(2'd0, 32'd0);
    tick(2);

    // Async reset mid-count with COUNT=5
    wrReg(2'd1, 32'd8);
    wrReg(2'd0, 32'd9);
    tick(5);
    rdChk("pre-reset count", 2'd2, 32'd5);
    #1 rst_n = 1'b0;
    #1;
    rdChk("async reset count", 2'd2, 32'd0);
    rdChk("async reset ctrl", 2'd0, 32'd0);
    rdChk("async reset preset", 2'd1, 32'd0);
    chk("async reset irq", {31'd0, irq}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    rdChk("post-reset idle count", 2'd2, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
